// File: rtl/sar_pkg.sv
// sar_pkg: state encoding and index-width helper shared by the SAR search controller and its settle counter
package sar_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, TRIAL = 2'd1, DONE = 2'd2} sar_state_t;
  function automatic int idx_bits(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
  localparam int SAR_IDX_W = idx_bits(2);
endpackage

// File: rtl/sar_settle_counter.sv
// sar_settle_counter: counts hold cycles of a trial; ports clk, rst_n (async low), clr, en in; last out when count reaches SETTLE_CYCLES-1
module sar_settle_counter
  import sar_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);
  localparam int CW = idx_bits(SETTLE_CYCLES);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign last = cnt == CW'(SETTLE_CYCLES - 1);
endmodule

// File: rtl/sar_search_controller.sv
// sar_search_controller: MSB-first successive-approximation search driving an external comparator; ports clk, rst_n (async low), start, cmp_gt in; trial, busy, done, result out; macro SAR_RESTART_EN lets start restart a running search
module sar_search_controller
  import sar_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_gt,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int IW = idx_bits(WIDTH);
  sar_state_t       state;
  logic [IW-1:0]    idx;
  logic             last;
  logic             restart;
  logic [WIDTH-1:0] msb;
  logic [WIDTH-1:0] dec_trial;
  assign msb = WIDTH'(1) << (WIDTH - 1);
`ifdef SAR_RESTART_EN
  assign restart = start && state == TRIAL;
`else
  assign restart = 1'b0;
`endif
  // trial after the decision edge: drop the current bit if too big, then try the next lower bit
  always_comb begin
    dec_trial = trial;
    if (cmp_gt) dec_trial[idx] = 1'b0;
    if (idx != '0) dec_trial[idx - 1'b1] = 1'b1;
  end
  sar_settle_counter #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state != TRIAL || last || restart),
    .en   (state == TRIAL),
    .last (last)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      trial  <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      idx    <= IW'(WIDTH - 1);
    end else begin
      done <= 1'b0;
      if ((state != TRIAL && start) || restart) begin
        state <= TRIAL;
        trial <= msb;
        idx   <= IW'(WIDTH - 1);
        busy  <= 1'b1;
      end else if (state == TRIAL) begin
        if (last) begin
          trial <= dec_trial;
          if (idx != '0) idx <= idx - 1'b1;
          else begin
            result <= dec_trial;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
      end else state <= IDLE;
    end
endmodule
